mash_combiner: RTL and testbench

MASH_COMBINER -- requirements
Module: mash_combiner

---
 rtl/mash_pkg.sv | 30 +++
 rtl/mash_diff.sv | 31 +++
 rtl/mash_combiner.sv | 175 +++++++++++++++++
 tb/tb_mash_combiner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
// Shared constants and types for the MASH carry combiner.
// Stage alignment delays line the stage-1 and stage-2 carries up with the
// stage-3 (or stage-2) double/single differentiation.
package mash_pkg;

  localparam int Y_WIDTH = 4;

  // 1-1-1 alignment: c1 delayed by 2, c2 by 1, c3 undelayed
  localparam int C1_DLY = 2;
  localparam int C2_DLY = 1;
  localparam int C3_DLY = 0;

  // 1-1 alignment: c1 delayed by 1, c2 undelayed
  localparam int C1_DLY_O2 = 1;
  localparam int C2_DLY_O2 = 0;

  // Correction range for each order
  localparam int Y_MIN    = -3;
  localparam int Y_MAX    = 4;
  localparam int Y_MIN_O2 = -1;
  localparam int Y_MAX_O2 = 2;

  typedef logic signed [Y_WIDTH-1:0] y_t;

  // Zero-extend a single carry bit into the signed correction width
  function automatic y_t carry_ext(input logic c);
    return {{(Y_WIDTH-1){1'b0}}, c};
  endfunction

endpackage

// File: rtl/mash_diff.sv
// First-difference cell: o_d = x[n] - x[n-1]. History advances on i_en and is
// zeroed by i_clr, which takes priority.
module mash_diff
  import mash_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  y_t   i_x,
  output y_t   o_d
);

  y_t x_q, x_d;

  // next history value: clear wins, otherwise capture on enable
  always_comb begin
    x_d = x_q;
    if (i_clr)     x_d = '0;
    else if (i_en) x_d = i_x;
  end

  // history register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) x_q <= '0;
    else          x_q <= x_d;
  end

  assign o_d = i_x - x_q;

endmodule

// File: rtl/mash_combiner.sv
// MASH carry combiner: merges EFM stage carries into a noise-shaped
// correction y and the instantaneous divide ratio N + y (clamped at zero).
// Build option: define MASH_ORDER3_EN for the 1-1-1 combiner; the default
// build is the 1-1 combiner with i_q3 unused.
module mash_combiner
  import mash_pkg::*;
#(
  parameter int P_INT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic                   i_clr,
  input  logic                   i_q1,
  input  logic                   i_q2,
  input  logic                   i_q3,
  input  logic [P_INT_WIDTH-1:0] i_int,
  output logic [Y_WIDTH-1:0]     o_y,
  output logic [P_INT_WIDTH:0]   o_div,
  output logic                   o_valid,
  output logic                   o_sat
);

  localparam int SW = P_INT_WIDTH + 2;

  logic adv;
  y_t   y_c;

  assign adv = i_valid & ~i_clr;

`ifdef MASH_ORDER3_EN
  // ---------------- 1-1-1 combiner ----------------
  logic [C1_DLY-1:0] c1_sr_q, c1_sr_d;
  logic [C2_DLY-1:0] c2_sr_q, c2_sr_d;
  y_t                c2_diff, c3_d1, c3_d2;
  logic              unused_c3_dly;

  assign unused_c3_dly = (C3_DLY != 0);

  // alignment delay lines for c1 and c2
  always_comb begin
    c1_sr_d = c1_sr_q;
    c2_sr_d = c2_sr_q;
    if (i_clr) begin
      c1_sr_d = '0;
      c2_sr_d = '0;
    end else if (adv) begin
      c1_sr_d = {c1_sr_q[C1_DLY-2:0], i_q1};
      c2_sr_d = i_q2;
    end
  end

  // delay line registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c1_sr_q <= '0;
      c2_sr_q <= '0;
    end else begin
      c1_sr_q <= c1_sr_d;
      c2_sr_q <= c2_sr_d;
    end
  end

  // c2[n-1] - c2[n-2]
  mash_diff u_c2_diff (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_valid),
    .i_clr  (i_clr),
    .i_x    (carry_ext(c2_sr_q[C2_DLY-1])),
    .o_d    (c2_diff)
  );

  // c3[n] - c3[n-1]
  mash_diff u_c3_diff1 (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_valid),
    .i_clr  (i_clr),
    .i_x    (carry_ext(i_q3)),
    .o_d    (c3_d1)
  );

  // second difference: c3[n] - 2*c3[n-1] + c3[n-2]
  mash_diff u_c3_diff2 (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_valid),
    .i_clr  (i_clr),
    .i_x    (c3_d1),
    .o_d    (c3_d2)
  );

  assign y_c = carry_ext(c1_sr_q[C1_DLY-1]) + c2_diff + c3_d2;
`else
  // ---------------- 1-1 combiner ----------------
  logic [C1_DLY_O2-1:0] c1_sr_q, c1_sr_d;
  y_t                   c2_diff;
  logic                 unused_q3;

  assign unused_q3 = i_q3 | (C2_DLY_O2 != 0);

  // alignment delay for c1
  always_comb begin
    c1_sr_d = c1_sr_q;
    if (i_clr)    c1_sr_d = '0;
    else if (adv) c1_sr_d = i_q1;
  end

  // delay register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) c1_sr_q <= '0;
    else          c1_sr_q <= c1_sr_d;
  end

  // c2[n] - c2[n-1]
  mash_diff u_c2_diff (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_valid),
    .i_clr  (i_clr),
    .i_x    (carry_ext(i_q2)),
    .o_d    (c2_diff)
  );

  assign y_c = carry_ext(c1_sr_q[C1_DLY_O2-1]) + c2_diff;
`endif

  // ---------------- divide ratio and output registers ----------------
  logic signed [SW-1:0]   sum;
  logic [Y_WIDTH-1:0]     o_y_q, o_y_d;
  logic [P_INT_WIDTH:0]   o_div_q, o_div_d;
  logic                   o_valid_q, o_valid_d;
  logic                   o_sat_q, o_sat_d;

  assign sum = $signed({2'b00, i_int}) + $signed({{(SW-Y_WIDTH){y_c[Y_WIDTH-1]}}, y_c});

  // next outputs: update on a qualified sample, clamp negative ratios to zero
  always_comb begin
    o_y_d     = o_y_q;
    o_div_d   = o_div_q;
    o_valid_d = adv;
    o_sat_d   = 1'b0;
    if (adv) begin
      o_y_d = y_c;
      if (sum[SW-1]) begin
        o_div_d = '0;
        o_sat_d = 1'b1;
      end else begin
        o_div_d = sum[P_INT_WIDTH:0];
      end
    end
  end

  // output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_y_q     <= '0;
      o_div_q   <= '0;
      o_valid_q <= 1'b0;
      o_sat_q   <= 1'b0;
    end else begin
      o_y_q     <= o_y_d;
      o_div_q   <= o_div_d;
      o_valid_q <= o_valid_d;
      o_sat_q   <= o_sat_d;
    end
  end

  assign o_y     = o_y_q;
  assign o_div   = o_div_q;
  assign o_valid = o_valid_q;
  assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_mash_combiner.sv
// Directed bench for mash_combiner; expectations follow the build's MASH order.
module tb_mash_combiner;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid, i_clr, i_q1, i_q2, i_q3;
  logic [W-1:0] i_int;
  logic [3:0]   o_y;
  logic [W:0]   o_div;
  logic         o_valid, o_sat;

  int checks = 0;
  int errors = 0;

  mash_combiner #(.P_INT_WIDTH(W)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .i_clr  (i_clr),
    .i_q1   (i_q1),
    .i_q2   (i_q2),
    .i_q3   (i_q3),
    .i_int  (i_int),
    .o_y    (o_y),
    .o_div  (o_div),
    .o_valid(o_valid),
    .o_sat  (o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic step(input logic v, input logic c, input logic q1, input logic q2,
                      input logic q3, input int n);
    i_valid = v; i_clr = c; i_q1 = q1; i_q2 = q2; i_q3 = q3; i_int = W'(n);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input int ey, input int ediv, input logic ev, input logic es);
    logic [3:0] ey4;
    logic [W:0] ed;
    ey4 = 4'(ey);
    ed  = (W+1)'(ediv);
    checks++;
    assert (o_valid === ev) else begin
      errors++; $error("FAIL %s o_valid got %b exp %b", tag, o_valid, ev);
    end
    checks++;
    assert (o_sat === es) else begin
      errors++; $error("FAIL %s o_sat got %b exp %b", tag, o_sat, es);
    end
    checks++;
    assert (o_y === ey4) else begin
      errors++; $error("FAIL %s o_y got %0d exp %0d", tag, $signed(o_y), $signed(ey4));
    end
    checks++;
    assert (o_div === ed) else begin
      errors++; $error("FAIL %s o_div got %0d exp %0d", tag, o_div, ed);
    end
  endtask

  int eb[4], cy[4], cd[4], dy[4], dd[4], py[4], pd[4];
  logic cs[4], ds[4], ps[4];

  initial begin
`ifdef MASH_ORDER3_EN
    eb = '{0, 0, 1, 0};
    cy = '{1, -2, 1, 0};  cd = '{2, 0, 2, 1};  cs = '{0, 1, 0, 0};
    dy = '{0, 1, -2, 2};  dd = '{0, 1, 0, 2};  ds = '{0, 0, 1, 0};
    py = '{0, 1, -1, 0};  pd = '{0, 1, 0, 0};  ps = '{0, 0, 1, 0};
`else
    eb = '{0, 1, 0, 0};
    cy = '{0, 0, 0, 0};   cd = '{1, 1, 1, 1};  cs = '{0, 0, 0, 0};
    dy = '{0, 0, 0, 0};   dd = '{0, 0, 0, 0};  ds = '{0, 0, 0, 0};
    py = '{1, -1, 0, 0};  pd = '{1, 0, 0, 0};  ps = '{0, 1, 0, 0};
`endif
    i_rst_n = 1'b0;
    i_valid = 0; i_clr = 0; i_q1 = 0; i_q2 = 0; i_q3 = 0; i_int = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset", 0, 0, 0, 0);
    i_rst_n = 1'b1;

    // constant N, no carries
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 100);
      chk("flat", 0, 100, 1, 0);
    end

    // load history, then reset mid-stream: history must be discarded
    step(1, 0, 1, 1, 1, 100);
    step(1, 0, 1, 1, 1, 100);
    do_reset();
    chk("midrst", 0, 0, 0, 0);

    // q1 impulse
    for (int i = 0; i < 4; i++) begin
      step(1, 0, i == 0, 0, 0, 10);
      chk("q1imp", eb[i], 10 + eb[i], 1, 0);
    end

    // q3 impulse with N=1, invalid cycle inserted after the clamp
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, i == 0, 1);
      chk("q3imp", cy[i], cd[i], 1, cs[i]);
      if (i == 1) begin
        step(0, 0, 1, 1, 1, 1);
        chk("hold", cy[1], cd[1], 0, 0);
      end
    end

    // q3 at samples 1 and 3 with N=0
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, (i == 1) || (i == 3), 0);
      chk("q3pair", dy[i], dd[i], 1, ds[i]);
    end

    // q2 impulse with N=0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, i == 0, 0, 0);
      chk("q2imp", py[i], pd[i], 1, ps[i]);
    end

    // valid gaps: carries toggling while invalid must not enter history
    do_reset();
    step(1, 0, 1, 0, 0, 5);
    chk("gap0", 0, 5, 1, 0);
    step(0, 0, 1, 1, 1, 5);
    chk("gapI0", 0, 5, 0, 0);
    step(1, 0, 0, 0, 0, 5);
`ifdef MASH_ORDER3_EN
    chk("gap1", 0, 5, 1, 0);
`else
    chk("gap1", 1, 6, 1, 0);
`endif
    step(0, 0, 1, 1, 1, 5);
`ifdef MASH_ORDER3_EN
    chk("gapI1", 0, 5, 0, 0);
`else
    chk("gapI1", 1, 6, 0, 0);
`endif
    step(1, 0, 0, 0, 0, 5);
`ifdef MASH_ORDER3_EN
    chk("gap2", 1, 6, 1, 0);
`else
    chk("gap2", 0, 5, 1, 0);
`endif
    step(0, 0, 0, 0, 0, 5);
`ifdef MASH_ORDER3_EN
    chk("gapI2", 1, 6, 0, 0);
`else
    chk("gapI2", 0, 5, 0, 0);
`endif

    // clear together with valid mid-stream
    do_reset();
    step(1, 0, 1, 0, 1, 3);
`ifdef MASH_ORDER3_EN
    chk("preclr", 1, 4, 1, 0);
`else
    chk("preclr", 0, 3, 1, 0);
`endif
    step(1, 1, 1, 1, 1, 3);
`ifdef MASH_ORDER3_EN
    chk("clr", 1, 4, 0, 0);
`else
    chk("clr", 0, 3, 0, 0);
`endif
    step(1, 0, 0, 0, 0, 3);
    chk("postclr0", 0, 3, 1, 0);
    step(1, 0, 0, 0, 0, 3);
    chk("postclr1", 0, 3, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
